vec_cpu_core: RTL and testbench

VEC_CPU_CORE -- requirements
Module: vec_cpu_core

---
 rtl/vec_cpu_core.sv | 147 ++++++++++++++
 tb/tb_vec_cpu_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cpu_core.sv
// vec_cpu_core: single-cycle 16-bit-instruction core with 8x32 registers and 4x8-bit lane ops.
// Optional VMUL lane multiply is compiled in only when VEC_CPU_VMUL_EN is defined.
module vec_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [31:0] mem_data,
    output logic        wr_enable,
    output logic [31:0] pc,
    output logic [31:0] cpu_addr,
    output logic [31:0] cpu_data
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_VADD = 4'h6;
    localparam logic [3:0] OP_VSUB = 4'h7;
    localparam logic [3:0] OP_VMUL = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_LD   = 4'hB;
    localparam logic [3:0] OP_ST   = 4'hC;
    localparam logic [3:0] OP_BEQ  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic [31:0] rf [0:7];

    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [5:0]  imm6;
    logic [8:0]  imm9;
    logic [11:0] imm12;
    logic [31:0] rd_v, ra_v, rb_v;
    logic [31:0] res, next_pc, ls_addr;
    logic        rf_we, st, halt_now;

    assign op    = instruction[15:12];
    assign rd    = instruction[11:9];
    assign ra    = instruction[8:6];
    assign rb    = instruction[5:3];
    assign imm6  = instruction[5:0];
    assign imm9  = instruction[8:0];
    assign imm12 = instruction[11:0];

    // r0 reads as zero regardless of storage contents
    assign rd_v = (rd == 3'd0) ? 32'h0 : rf[rd];
    assign ra_v = (ra == 3'd0) ? 32'h0 : rf[ra];
    assign rb_v = (rb == 3'd0) ? 32'h0 : rf[rb];

    assign ls_addr = ra_v + {26'h0, imm6};

    // Lane ops: each byte computed alone so nothing crosses lane borders
    function automatic logic [31:0] lane_op(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [1:0]  kind);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            case (kind)
                2'd0:    r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
                2'd1:    r[8*i +: 8] = a[8*i +: 8] - b[8*i +: 8];
                default: r[8*i +: 8] = a[8*i +: 8] * b[8*i +: 8];
            endcase
        end
        return r;
    endfunction

    // Decode and execute the current instruction
    always_comb begin
        res      = '0;
        rf_we    = 1'b0;
        st       = 1'b0;
        halt_now = 1'b0;
        next_pc  = pc + 32'd1;
        cpu_addr = '0;
        cpu_data = '0;
        case (op)
            OP_ADD:  begin res = ra_v + rb_v; rf_we = 1'b1; end
            OP_SUB:  begin res = ra_v - rb_v; rf_we = 1'b1; end
            OP_AND:  begin res = ra_v & rb_v; rf_we = 1'b1; end
            OP_OR:   begin res = ra_v | rb_v; rf_we = 1'b1; end
            OP_XOR:  begin res = ra_v ^ rb_v; rf_we = 1'b1; end
            OP_VADD: begin res = lane_op(ra_v, rb_v, 2'd0); rf_we = 1'b1; end
            OP_VSUB: begin res = lane_op(ra_v, rb_v, 2'd1); rf_we = 1'b1; end
`ifdef VEC_CPU_VMUL_EN
            OP_VMUL: begin res = lane_op(ra_v, rb_v, 2'd2); rf_we = 1'b1; end
`else
            OP_VMUL: ;
`endif
            OP_LDI:  begin res = {23'h0, imm9}; rf_we = 1'b1; end
            OP_ADDI: begin res = ra_v + {26'h0, imm6}; rf_we = 1'b1; end
            OP_LD: begin
                cpu_addr = ls_addr;
                res      = mem_data;
                rf_we    = 1'b1;
            end
            OP_ST: begin
                cpu_addr = ls_addr;
                cpu_data = rd_v;
                st       = 1'b1;
            end
            OP_BEQ: begin
                if (rd_v == ra_v)
                    next_pc = pc + 32'd1 + {{26{imm6[5]}}, imm6};
            end
            OP_JMP:  next_pc = pc + 32'd1 + {{20{imm12[11]}}, imm12};
            OP_HALT: begin next_pc = pc; halt_now = 1'b1; end
            OP_NOP:  ;
            default: ;
        endcase
        if (state == HALTED) begin
            rf_we   = 1'b0;
            st      = 1'b0;
            next_pc = pc;
        end
    end

    // Store strobe dies immediately on reset or while halted
    assign wr_enable = st & reset & (state == RUN);

    // Architectural state: pc, halt state and register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            state <= RUN;
            for (int i = 0; i < 8; i++)
                rf[i] <= '0;
        end else begin
            pc <= next_pc;
            if (halt_now)
                state <= HALTED;
            if (rf_we && rd != 3'd0)
                rf[rd] <= res;
        end
    end

endmodule

// File: tb/tb_vec_cpu_core.sv
// tb_vec_cpu_core: directed vector table plus hand sequences for vec_cpu_core.
// Instruction and data memories are modelled here around the DUT.
module tb_vec_cpu_core;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [31:0] mem_data;
    logic        wr_enable;
    logic [31:0] pc;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;

    logic [15:0] imem [0:63];
    logic [31:0] dmem [0:63];

    int tests;
    int fails;

    vec_cpu_core #(.RESET_PC(32'h0)) dut (
        .clk(clk),
        .reset(reset),
        .instruction(instruction),
        .mem_data(mem_data),
        .wr_enable(wr_enable),
        .pc(pc),
        .cpu_addr(cpu_addr),
        .cpu_data(cpu_data)
    );

    assign instruction = imem[pc[5:0]];
    assign mem_data    = dmem[cpu_addr[5:0]];

    always #5 clk = ~clk;

    always @(posedge clk)
        if (wr_enable)
            dmem[cpu_addr[5:0]] <= cpu_data;

    typedef struct {
        logic [127:0] prog;
        int           st_pc;
        logic [31:0]  exp;
        string        name;
    } vec_t;

    vec_t vt [0:13];

    localparam logic [15:0] HLT = 16'hF000;
    localparam logic [15:0] NOP = 16'h0000;

    function automatic logic [15:0] rr(input logic [3:0] op, input int d,
                                       input int a, input int b);
        logic [31:0] dv, av, bv;
        dv = d; av = a; bv = b;
        return {op, dv[2:0], av[2:0], bv[2:0], 3'b000};
    endfunction

    function automatic logic [15:0] ri(input logic [3:0] op, input int d,
                                       input int a, input int imm);
        logic [31:0] dv, av, iv;
        dv = d; av = a; iv = imm;
        return {op, dv[2:0], av[2:0], iv[5:0]};
    endfunction

    function automatic logic [15:0] ldi(input int d, input int imm);
        logic [31:0] dv, iv;
        dv = d; iv = imm;
        return {4'h9, dv[2:0], iv[8:0]};
    endfunction

    function automatic logic [15:0] jmp(input int imm);
        logic [31:0] iv;
        iv = imm;
        return {4'hE, iv[11:0]};
    endfunction

    function automatic logic [127:0] p5(input logic [15:0] a, b, c, d, e);
        logic [127:0] r;
        r = {8{HLT}};
        r[15:0]  = a;
        r[31:16] = b;
        r[47:32] = c;
        r[63:48] = d;
        r[79:64] = e;
        return r;
    endfunction

    task automatic check(input string nm, input logic [64:0] act,
                         input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic load(input logic [127:0] p);
        for (int i = 0; i < 64; i++)
            imem[i] = HLT;
        for (int i = 0; i < 8; i++)
            imem[i] = p[16*i +: 16];
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] stp;
        reset = 1'b0;
        load(v.prog);
        do_reset();
        stp = v.st_pc;
        for (int k = 0; k < 20 && pc != stp; k++)
            step();
        if (pc != stp) begin
            check({v.name, " timeout"}, {33'h0, pc}, {33'h0, stp});
        end else begin
            check(v.name, {wr_enable, cpu_addr, cpu_data},
                  {1'b1, 32'h0, v.exp});
        end
    endtask

    initial begin
        logic [31:0] vmul_exp;
        clk   = 1'b0;
        reset = 1'b0;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = HLT;
            dmem[i] = '0;
        end
        dmem[16] = 32'h01FF7F80;
        dmem[17] = 32'h01010101;
        dmem[18] = 32'h10020304;
`ifdef VEC_CPU_VMUL_EN
        vmul_exp = 32'h00040910;
`else
        vmul_exp = 32'h00000055;
`endif

        vt[0]  = '{p5(ldi(1,5), ldi(2,3), rr(4'h1,3,1,2), ri(4'hC,3,0,0), HLT), 3, 32'd8, "add"};
        vt[1]  = '{p5(ldi(1,5), ldi(2,3), rr(4'h2,4,2,1), ri(4'hC,4,0,0), HLT), 3, 32'hFFFFFFFE, "sub"};
        vt[2]  = '{p5(ldi(1,'h1F0), ldi(2,'hFF), rr(4'h3,3,1,2), ri(4'hC,3,0,0), HLT), 3, 32'h0F0, "and"};
        vt[3]  = '{p5(ldi(1,'h1F0), ldi(2,'hFF), rr(4'h4,3,1,2), ri(4'hC,3,0,0), HLT), 3, 32'h1FF, "or"};
        vt[4]  = '{p5(ldi(1,'h1F0), ldi(2,'hFF), rr(4'h5,3,1,2), ri(4'hC,3,0,0), HLT), 3, 32'h10F, "xor"};
        vt[5]  = '{p5(ri(4'hB,1,0,16), ri(4'hB,2,0,17), rr(4'h6,3,1,2), ri(4'hC,3,0,0), HLT), 3, 32'h02008081, "vadd"};
        vt[6]  = '{p5(ri(4'hB,1,0,16), ri(4'hB,2,0,17), rr(4'h7,3,2,1), ri(4'hC,3,0,0), HLT), 3, 32'h00028281, "vsub"};
        vt[7]  = '{p5(ri(4'hB,1,0,18), ri(4'hB,2,0,18), ldi(3,'h55), rr(4'h8,3,1,2), ri(4'hC,3,0,0)), 4, vmul_exp, "vmul"};
        vt[8]  = '{p5(ldi(1,'h1FF), ri(4'hA,2,1,63), ri(4'hC,2,0,0), HLT, HLT), 2, 32'h23E, "addi"};
        vt[9]  = '{p5(ldi(0,7), ri(4'hC,0,0,0), HLT, HLT, HLT), 1, 32'h0, "r0_discard"};
        vt[10] = '{p5(ldi(1,5), ri(4'hA,1,1,1), ri(4'hA,1,1,1), ri(4'hC,1,0,0), HLT), 3, 32'd7, "rw_order"};
        vt[11] = '{p5(ldi(1,10), ri(4'hB,2,1,6), ri(4'hC,2,0,0), HLT, HLT), 2, 32'h01FF7F80, "ld_offset"};
        vt[12] = '{p5(ldi(1,9), NOP, ri(4'hC,1,0,0), HLT, HLT), 2, 32'd9, "nop"};
        vt[13] = '{p5(ri(4'hC,1,0,0), HLT, HLT, HLT, HLT), 0, 32'h0, "reset_regs"};

        for (int i = 0; i < 14; i++)
            run_vec(vt[i]);

        // Store then load back through data memory
        load(p5(ldi(1,10), ri(4'hC,1,0,4), ri(4'hB,2,0,4), ri(4'hC,2,0,0), HLT));
        do_reset();
        check("ldi_bus", {wr_enable, cpu_addr, cpu_data}, 65'h0);
        step();
        check("st_bus", {wr_enable, cpu_addr, cpu_data}, {1'b1, 32'd4, 32'd10});
        step();
        check("ld_bus", {wr_enable, cpu_addr, cpu_data}, {1'b0, 32'd4, 32'd0});
        step();
        check("ld_value", {wr_enable, cpu_addr, cpu_data}, {1'b1, 32'd0, 32'd10});

        // Branch and jump sequence
        for (int i = 0; i < 64; i++)
            imem[i] = HLT;
        imem[0] = ldi(1, 1);
        imem[1] = NOP;
        imem[2] = jmp(3);
        imem[6] = ri(4'hD, 1, 0, 5);
        imem[7] = ri(4'hD, 0, 0, -1);
        do_reset();
        step();
        check("pc_after_ldi", {33'h0, pc}, 65'd1);
        step();
        step();
        check("jmp_plus3", {33'h0, pc}, 65'd6);
        step();
        check("beq_not_taken", {33'h0, pc}, 65'd7);
        step();
        check("beq_self_1", {33'h0, pc}, 65'd7);
        step();
        check("beq_self_2", {33'h0, pc}, 65'd7);

        // Halt holds until reset, even if the fetched word changes
        for (int i = 0; i < 64; i++)
            imem[i] = NOP;
        imem[5] = HLT;
        do_reset();
        for (int i = 0; i < 5; i++)
            step();
        check("reach_halt", {33'h0, pc}, 65'd5);
        step();
        imem[5] = ri(4'hC, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            check("halted", {32'h0, wr_enable, pc}, {32'h0, 1'b0, 32'd5});
            step();
        end
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_pc", {32'h0, wr_enable, pc}, 65'h0);
        imem[0] = NOP;
        @(negedge clk);
        reset = 1'b1;
        step();
        check("run_after_halt", {33'h0, pc}, 65'd1);

        // Reset mid-store aborts the write
        dmem[8] = 32'h0;
        load(p5(ldi(1,9), ri(4'hC,1,0,8), HLT, HLT, HLT));
        do_reset();
        step();
        check("st_strobe", {64'h0, wr_enable}, 65'd1);
        #2;
        reset = 1'b0;
        #1;
        check("st_strobe_reset", {64'h0, wr_enable}, 65'd0);
        step();
        check("st_aborted", {33'h0, dmem[8]}, 65'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
